rv32i_if_fetch: RTL

- Instruction-fetch stage of the 5-stage RV32I pipeline. Sits directly upstream of the decode stage.
- Owns the PC and drives a synchronous instruction memory with 1-cycle read latency.
- Delivers iw_out/pc_out to decode. Accepts jump redirects from decode, supports a decode stall with a 1-entry skid buffer, and halts fetch after issuing EBREAK.

---
 rtl/rv32i_if_fetch.sv | 122 ++++++++++++
 1 files changed

// File: rtl/rv32i_if_fetch.sv
// RV32I instruction-fetch stage: owns the PC, drives a 1-cycle-latency instruction memory,
// handles decode redirects, decode stalls via a one-entry skid buffer, and halts on EBREAK.
//
// state | meaning
// RUN   | fetching; one request in flight at most
// HALT  | EBREAK issued; emit NOPs until reset
module rv32i_if_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_IW    = 32'h0000_0013,
    parameter logic [31:0] EBREAK_IW = 32'h0010_0073
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        jump_en_in,
    input  logic [31:0] jump_addr_in,
    input  logic        stall_in,
    output logic        imem_rd_en,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    output logic [31:0] iw_out,
    output logic [31:0] pc_out,
    output logic        jump_en_out,
    output logic        halted_out
);

    typedef enum logic {RUN, HALT} state_t;

    state_t      state;
    logic [31:0] pc_f;
    logic        req_v;
    logic [31:0] pc_req;
    logic        sb_v;
    logic [31:0] sb_iw;
    logic [31:0] sb_pc;

    logic [31:0] jump_tgt;
    logic        sel_v;
    logic [31:0] sel_iw;
    logic [31:0] sel_pc;

    assign jump_tgt = jump_addr_in & ~32'h0000_0003;

    always_comb begin
        imem_rd_en = 1'b0;
        imem_addr  = pc_f;
        if (!reset && state == RUN) begin
            if (jump_en_in) begin
                imem_rd_en = 1'b1;
                imem_addr  = jump_tgt;
            end else if (!stall_in) begin
                imem_rd_en = 1'b1;
            end
        end
    end

    // The skid entry is older than anything arriving from memory, so it goes first.
    always_comb begin
        sel_v  = 1'b0;
        sel_iw = NOP_IW;
        sel_pc = pc_out;
        if (sb_v) begin
            sel_v  = 1'b1;
            sel_iw = sb_iw;
            sel_pc = sb_pc;
        end else if (req_v) begin
            sel_v  = 1'b1;
            sel_iw = imem_data;
            sel_pc = pc_req;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= RUN;
            pc_f        <= RESET_PC;
            req_v       <= 1'b0;
            pc_req      <= RESET_PC;
            sb_v        <= 1'b0;
            sb_iw       <= NOP_IW;
            sb_pc       <= 32'h0;
            iw_out      <= NOP_IW;
            pc_out      <= 32'h0;
            jump_en_out <= 1'b0;
            halted_out  <= 1'b0;
        end else begin
            jump_en_out <= jump_en_in && (state == RUN);
            if (state == HALT) begin
                iw_out <= NOP_IW;
                req_v  <= 1'b0;
                sb_v   <= 1'b0;
            end else if (jump_en_in) begin
                pc_req <= jump_tgt;
                pc_f   <= jump_tgt + 32'd4;
                req_v  <= 1'b1;
                sb_v   <= 1'b0;
                iw_out <= NOP_IW;
            end else if (stall_in) begin
                req_v <= 1'b0;
                if (req_v) begin
                    sb_v  <= 1'b1;
                    sb_iw <= imem_data;
                    sb_pc <= pc_req;
                end
            end else begin
                pc_req <= pc_f;
                pc_f   <= pc_f + 32'd4;
                req_v  <= 1'b1;
                sb_v   <= 1'b0;
                iw_out <= sel_iw;
                if (sel_v) begin
                    pc_out <= sel_pc;
                end
                if (sel_v && sel_iw == EBREAK_IW) begin
                    state      <= HALT;
                    halted_out <= 1'b1;
                    req_v      <= 1'b0;
                end
            end
        end
    end

endmodule
